// File: rtl/s_axi_regfile_if.sv
// AXI4 single-beat bus bundle for s_axi_regfile: AW, W, B, AR and R channels.
interface s_axi_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]     awid_i;
  logic [ADDR_W-1:0]   awaddr_i;
  logic                awvalid_i;
  logic                awready_o;
  logic [DATA_W-1:0]   wdata_i;
  logic [DATA_W/8-1:0] wstrb_i;
  logic                wvalid_i;
  logic                wready_o;
  logic [ID_W-1:0]     bid_o;
  logic [1:0]          bresp_o;
  logic                bvalid_o;
  logic                bready_i;
  logic [ID_W-1:0]     arid_i;
  logic [ADDR_W-1:0]   araddr_i;
  logic                arvalid_i;
  logic                arready_o;
  logic [ID_W-1:0]     rid_o;
  logic [DATA_W-1:0]   rdata_o;
  logic [1:0]          rresp_o;
  logic                rlast_o;
  logic                rvalid_o;
  logic                rready_i;

  modport slave (
    input  awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           arid_i, araddr_i, arvalid_i, rready_i,
    output awready_o, wready_o, bid_o, bresp_o, bvalid_o,
           arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport master (
    output awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           arid_i, araddr_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bid_o, bresp_o, bvalid_o,
           arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/s_axi_regfile.sv
// AXI4 single-beat slave register bank with byte-strobe writes and a flat register bus.
// Optional S_AXI_REGFILE_WR_PULSE_EN adds wr_pulse_o, one-cycle per-register write strobes.
module s_axi_regfile #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       NUM_REGS  = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       areset,
  s_axi_regfile_if.slave             axi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
`ifdef S_AXI_REGFILE_WR_PULSE_EN
  ,output logic [NUM_REGS-1:0]       wr_pulse_o
`endif
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned AIDX_W = ADDR_W - OFF_W;
  localparam logic [AIDX_W-1:0] NUM_REGS_A = AIDX_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic              aw_held, w_held, aw_ok_q;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [ID_W-1:0]   awid_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs, commit;
  logic              aw_ok_in, ar_ok, cur_ok;
  logic [IDX_W-1:0]  aw_idx_in, ar_idx, cur_idx;
  logic [ID_W-1:0]   cur_awid;
  logic [DATA_W-1:0] cur_wdata, old_word, wr_word, rd_word;
  logic [STRB_W-1:0] cur_wstrb;
  logic              unused_addr_lsb;

  assign aw_ok_in  = axi.awaddr_i[ADDR_W-1:OFF_W] < NUM_REGS_A;
  assign aw_idx_in = axi.awaddr_i[OFF_W +: IDX_W];
  assign ar_ok     = axi.araddr_i[ADDR_W-1:OFF_W] < NUM_REGS_A;
  assign ar_idx    = axi.araddr_i[OFF_W +: IDX_W];
  assign unused_addr_lsb = ^{axi.awaddr_i[OFF_W-1:0], axi.araddr_i[OFF_W-1:0]};

  // AW and W are merged from either the held copy or the live bus, so a beat that
  // completes the pair commits on its own handshake edge.
  always_comb begin
    aw_rdy    = (wstate == W_IDLE) && !aw_held;
    w_rdy     = (wstate == W_IDLE) && !w_held;
    ar_rdy    = (rstate == R_IDLE);
    aw_hs     = axi.awvalid_i && aw_rdy;
    w_hs      = axi.wvalid_i && w_rdy;
    ar_hs     = axi.arvalid_i && ar_rdy;
    cur_awid  = aw_held ? awid_q   : axi.awid_i;
    cur_ok    = aw_held ? aw_ok_q  : aw_ok_in;
    cur_idx   = aw_held ? aw_idx_q : aw_idx_in;
    cur_wdata = w_held  ? wdata_q  : axi.wdata_i;
    cur_wstrb = w_held  ? wstrb_q  : axi.wstrb_i;
    commit    = (wstate == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    old_word  = regs_o[cur_idx*DATA_W +: DATA_W];
    wr_word   = old_word;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (cur_wstrb[b]) wr_word[8*b +: 8] = cur_wdata[8*b +: 8];
    end
    rd_word = ar_ok ? regs_o[ar_idx*DATA_W +: DATA_W] : '0;

    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if (commit) wstate_nxt = W_RESP;
      W_RESP:  if (axi.bready_i) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_DATA;
      R_DATA:  if (axi.rready_i) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  assign axi.awready_o = aw_rdy;
  assign axi.wready_o  = w_rdy;
  assign axi.arready_o = ar_rdy;
  assign axi.bvalid_o  = (wstate == W_RESP);
  assign axi.rvalid_o  = (rstate == R_DATA);
  assign axi.rlast_o   = (rstate == R_DATA);

  always_ff @(posedge clk) begin
    if (areset) begin
      wstate      <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_ok_q     <= 1'b0;
      aw_idx_q    <= '0;
      awid_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      axi.bid_o   <= '0;
      axi.bresp_o <= RESP_OKAY;
    end else begin
      wstate <= wstate_nxt;
      if (aw_hs && !commit) begin
        aw_held  <= 1'b1;
        aw_ok_q  <= aw_ok_in;
        aw_idx_q <= aw_idx_in;
        awid_q   <= axi.awid_i;
      end
      if (w_hs && !commit) begin
        w_held  <= 1'b1;
        wdata_q <= axi.wdata_i;
        wstrb_q <= axi.wstrb_i;
      end
      if (commit) begin
        aw_held     <= 1'b0;
        w_held      <= 1'b0;
        axi.bid_o   <= cur_awid;
        axi.bresp_o <= cur_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic [DATA_W-1:0] q;
    always_ff @(posedge clk) begin
      if (areset) q <= RESET_VAL;
      else if (commit && cur_ok && (cur_idx == IDX_W'(k))) q <= wr_word;
    end
    assign regs_o[k*DATA_W +: DATA_W] = q;
  end

  // rd_word comes from the pre-edge register contents, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (areset) begin
      rstate      <= R_IDLE;
      axi.rid_o   <= '0;
      axi.rdata_o <= '0;
      axi.rresp_o <= RESP_OKAY;
    end else begin
      rstate <= rstate_nxt;
      if (ar_hs) begin
        axi.rid_o   <= axi.arid_i;
        axi.rdata_o <= rd_word;
        axi.rresp_o <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

`ifdef S_AXI_REGFILE_WR_PULSE_EN
  always_ff @(posedge clk) begin
    if (areset) begin
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit && cur_ok) wr_pulse_o[cur_idx] <= 1'b1;
    end
  end
`endif
endmodule
